telemetry_sched: RTL and testbench

- Schedules periodic telemetry packets from the eBike sensor-conditioning datapath onto the shared UART transmitter (UART_tx).
- On each period tick it snapshots the battery, average-current and average-torque readings.
- It then sequences an 8-byte framed packet through the UART trmt/tx_done handshake, one byte at a time.
- It owns the UART transmitter exclusively: it is the only block that drives trmt and tx_data.

---
 rtl/telemetry_if.sv | 17 +
 rtl/telemetry_sched.sv | 77 +++++++
 tb/tb_telemetry_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/telemetry_if.sv
// telemetry_if: sensor snapshot inputs and UART transmit handshake of the telemetry scheduler.
interface telemetry_if;
   logic        en;
   logic [11:0] batt;
   logic [11:0] curr;
   logic [11:0] torque;
   logic        tx_done;
   logic        trmt;
   logic [7:0]  tx_data;
   logic        busy;
   logic        pkt_done;
   logic        missed;
   modport master (input en, batt, curr, torque, tx_done,
                   output trmt, tx_data, busy, pkt_done, missed);
   modport slave  (output en, batt, curr, torque, tx_done,
                   input trmt, tx_data, busy, pkt_done, missed);
endinterface

// File: rtl/telemetry_sched.sv
// telemetry_sched: sends a periodic 8-byte framed battery/current/torque packet through UART_tx.
module telemetry_sched #(
   parameter bit         FAST_SIM = 1'b1,
   parameter logic [7:0] DELIM1   = 8'hAA,
   parameter logic [7:0] DELIM2   = 8'h55
) (
   input  logic         clk,
   input  logic         rst_n,
   telemetry_if.master  bus
);
   localparam int W = FAST_SIM ? 12 : 20;
   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
   state_t      state_q, state_d;
   logic [W-1:0] cnt_q;
   logic [11:0] batt_s_q, batt_s_d, curr_s_q, curr_s_d, torque_s_q, torque_s_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [7:0]  pkt [8];
   logic        tick, pkt_done;
   assign tick = &cnt_q;
   assign pkt = '{DELIM1, DELIM2,
                  {4'h0, batt_s_q[11:8]}, batt_s_q[7:0],
                  {4'h0, curr_s_q[11:8]}, curr_s_q[7:0],
                  {4'h0, torque_s_q[11:8]}, torque_s_q[7:0]};
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      batt_s_d   = batt_s_q;
      curr_s_d   = curr_s_q;
      torque_s_d = torque_s_q;
      tx_data_d  = tx_data_q;
      pkt_done   = 1'b0;
      case (state_q)
         IDLE: if (tick && bus.en) begin
            batt_s_d   = bus.batt;
            curr_s_d   = bus.curr;
            torque_s_d = bus.torque;
            idx_d      = 3'd0;
            tx_data_d  = DELIM1;
            state_d    = SEND;
         end
         SEND: state_d = WAIT;
         WAIT: if (bus.tx_done) begin
            pkt_done  = idx_q == 3'd7;
            idx_d     = pkt_done ? idx_q : idx_q + 3'd1;
            tx_data_d = pkt_done ? tx_data_q : pkt[idx_q + 3'd1];
            state_d   = pkt_done ? IDLE : SEND;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         state_q    <= IDLE;
         idx_q      <= '0;
         batt_s_q   <= '0;
         curr_s_q   <= '0;
         torque_s_q <= '0;
         tx_data_q  <= '0;
      end else begin
         cnt_q      <= cnt_q + W'(1);
         state_q    <= state_d;
         idx_q      <= idx_d;
         batt_s_q   <= batt_s_d;
         curr_s_q   <= curr_s_d;
         torque_s_q <= torque_s_d;
         tx_data_q  <= tx_data_d;
      end
   end
   // A tick that lands while a packet is in flight is dropped, not queued.
   assign bus.trmt     = state_q == SEND;
   assign bus.busy     = state_q != IDLE;
   assign bus.missed   = tick && state_q != IDLE;
   assign bus.pkt_done = pkt_done;
   assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_telemetry_sched.sv
// tb_telemetry_sched: random sensor/UART stimulus against a packet-level reference with a trmt scoreboard.
module tb_telemetry_sched;
   logic clk, rst_n;
   telemetry_if bus ();
   telemetry_sched #(.FAST_SIM(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct { longint c; logic [7:0] d; } exp_t;
   exp_t        q[$];
   int          total, bad, delay, ridx;
   longint      cyc, rel, rlast, ph;
   bit          rbusy, stalled, did_reset;
   logic [7:0]  pkt [8];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
      end
   endtask

   // Byte scoreboard: every trmt must match the next predicted byte and its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.trmt) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL trmt_unexpected cyc=%0d data=%h", cyc, bus.tx_data);
            end else begin
               e = q.pop_front();
               if (e.c != cyc || e.d !== bus.tx_data) begin
                  bad++;
                  $display("FAIL trmt_byte got cyc=%0d data=%h exp cyc=%0d data=%h", cyc, bus.tx_data, e.c, e.d);
               end
            end
         end else if (q.size() != 0 && q[0].c <= cyc) begin
            total++;
            bad++;
            $display("FAIL trmt_missing got none at cyc=%0d exp data=%h", cyc, q[0].d);
            void'(q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_trmt", bus.trmt, 0);
      q.delete();
      rbusy = 0;
      bus.tx_done = 1'b1;
      delay = 0;
      repeat (3) begin
         @(negedge clk);
         cyc++;
      end
      #1 rst_n = 1'b1;
      rel = cyc;
      did_reset = 1;
   endtask

   task automatic drive();
      ph = cyc / 4096;
      bus.en = !(ph == 2 || ph == 3) && (ph != 7 || $urandom_range(0, 1) == 1);
      if (ph == 1 && rbusy && ridx == 2) bus.batt = 12'h123;
      if (ph >= 5 && $urandom_range(0, 49) == 0) begin
         bus.batt   = 12'($urandom);
         bus.curr   = 12'($urandom);
         bus.torque = 12'($urandom);
      end
      if (bus.trmt) begin
         bus.tx_done = 1'b0;
         if (ph == 5 && ridx == 3 && !stalled) begin
            delay = 5000;
            stalled = 1;
         end else delay = $urandom_range(2, 40);
      end else if (!bus.tx_done && delay > 0) begin
         delay--;
         if (delay == 0) bus.tx_done = 1'b1;
      end
      if (ph >= 9 && !did_reset && rbusy && ridx == 4 && cyc > rlast) do_reset();
   endtask

   task automatic step();
      bit tk, acc;
      tk  = ((cyc - rel) % 4096) == 4095;
      acc = rbusy && cyc > rlast && bus.tx_done;
      chk("busy", bus.busy, rbusy);
      chk("missed", bus.missed, tk && rbusy);
      chk("pkt_done", bus.pkt_done, acc && ridx == 7);
      if (!rbusy && tk && bus.en) begin
         pkt = '{8'hAA, 8'h55, {4'h0, bus.batt[11:8]}, bus.batt[7:0],
                 {4'h0, bus.curr[11:8]}, bus.curr[7:0],
                 {4'h0, bus.torque[11:8]}, bus.torque[7:0]};
         rbusy = 1;
         ridx  = 0;
         rlast = cyc + 1;
         q.push_back('{cyc + 1, pkt[0]});
      end else if (acc) begin
         if (ridx == 7) rbusy = 0;
         else begin
            ridx++;
            rlast = cyc + 1;
            q.push_back('{cyc + 1, pkt[ridx]});
         end
      end
      cyc++;
   endtask

   initial begin
      int n;
      total = 0; bad = 0; cyc = 0; rel = 0; rbusy = 0; ridx = 0; rlast = 0;
      delay = 0; stalled = 0; did_reset = 0;
      rst_n = 1'b0;
      bus.en = 1'b1;
      bus.batt = 12'hA98;
      bus.curr = 12'h3C4;
      bus.torque = 12'h700;
      bus.tx_done = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      chk("reset_trmt", bus.trmt, 0);
      chk("reset_tx_data", bus.tx_data, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_pkt_done", bus.pkt_done, 0);
      chk("reset_missed", bus.missed, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      rel = cyc;
      #1 step();
      n = 0;
      while (!(n >= 53000 && !rbusy) && n < 60000) begin
         @(negedge clk);
         #1 drive();
         #1 step();
         n++;
      end
      if (n >= 60000) begin
         bad++;
         $display("FAIL timeout got busy=%0d exp busy=0", rbusy);
      end
      @(negedge clk);
      #2 chk("queue_empty", q.size(), 0);
      chk("stall_seen", stalled, 1);
      chk("reset_seen", did_reset, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
